// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, status codes and default halt word for the run controller
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  typedef enum logic [1:0] {ST_HALT, ST_TIMEOUT, ST_PC_RANGE, ST_ABORT} status_e;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: program-load stream handshake between source and controller
interface cpu_run_ctrl_if #(parameter int unsigned WORD_W = 32) ();
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_last;
  logic [WORD_W-1:0] ld_data;
  modport master (output ld_valid, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/cpu_ram_image.sv
// cpu_ram_image: flat program image register array with sync clear and indexed write
module cpu_ram_image #(
  parameter int unsigned RAM_SIZE = 8,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [WORD_W-1:0]          wdata_i,
  output logic [RAM_SIZE*WORD_W-1:0] ram_o
);
  logic [RAM_SIZE-1:0][WORD_W-1:0] mem_q;
  assign ram_o = mem_q;
  // Clear wins over write; word 0 sits in the least significant slice
  always_ff @(posedge clk)
    if (reset || clr_i) mem_q <= '0;
    else if (we_i) mem_q[idx_i] <= wdata_i;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: loads a program image, runs the core and reports halt/timeout/pc-range/abort
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       RAM_SIZE  = 8,
  parameter int unsigned       WORD_W    = 32,
  parameter int unsigned       PC_W      = 8,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [WORD_W-1:0] HALT_WORD = WORD_W'(HALT_WORD_DEF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           max_cycles,
  cpu_run_ctrl_if.slave              ld,
  output logic [RAM_SIZE*WORD_W-1:0] ram,
  output logic                       core_reset,
  input  logic [PC_W-1:0]            core_pc,
  input  logic [WORD_W-1:0]          core_ir,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 status,
  output logic [CNT_W-1:0]           cycles
);
  localparam int unsigned IDX_W = RAM_SIZE > 1 ? $clog2(RAM_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_SIZE - 1);
  state_e            state_q;
  status_e           status_q, stop_st;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cycles_q, max_q;
  logic              ld_ready_q, core_reset_q, busy_q, done_q;
  logic              idle, active, beat, halt, pc_hi, tmo, stop, clr;
  assign ld.ld_ready = ld_ready_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycles      = cycles_q;
  // Termination checks; the first RUN cycle is the core's first clock, so cycles==0 masks halt/pc
  always_comb begin
    idle    = state_q == IDLE || state_q == DONE;
    active  = state_q == LOAD || state_q == RUN;
    beat    = state_q == LOAD && ld.ld_valid && ld_ready_q;
    halt    = cycles_q != '0 && core_ir == HALT_WORD;
    pc_hi   = cycles_q != '0 && 32'(core_pc) >= RAM_SIZE;
    tmo     = max_q != '0 && cycles_q == max_q;
    stop    = active && (abort || (state_q == RUN && (halt || pc_hi || tmo)));
    stop_st = abort ? ST_ABORT : halt ? ST_HALT : pc_hi ? ST_PC_RANGE : ST_TIMEOUT;
    clr     = idle && start;
  end
  cpu_ram_image #(.RAM_SIZE(RAM_SIZE), .WORD_W(WORD_W), .IDX_W(IDX_W)) u_img (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .we_i    (beat && !abort),
    .idx_i   (idx_q),
    .wdata_i (ld.ld_data),
    .ram_o   (ram)
  );
  // Run FSM with registered handshake, core reset and status outputs
  always_ff @(posedge clk)
    if (reset) begin
      state_q      <= IDLE;
      status_q     <= ST_HALT;
      idx_q        <= '0;
      cycles_q     <= '0;
      max_q        <= '0;
      ld_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (clr) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      cycles_q   <= '0;
      max_q      <= max_cycles;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else if (stop) begin
      state_q      <= DONE;
      status_q     <= stop_st;
      ld_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b1;
    end else if (beat) begin
      idx_q <= idx_q + 1'b1;
      if (ld.ld_last || idx_q == LAST_IDX) begin
        state_q      <= RUN;
        ld_ready_q   <= 1'b0;
        core_reset_q <= 1'b0;
      end
    end else if (state_q == RUN)
      cycles_q <= &cycles_q ? cycles_q : cycles_q + 1'b1;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for the run controller
module tb_cpu_run_ctrl;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0]  max_cycles = '0;
  logic [255:0] ram;
  logic         core_reset, busy, done;
  logic [1:0]   status;
  logic [15:0]  cycles;
  logic [7:0]   core_pc, m_pc, man_pc = '0;
  logic [31:0]  core_ir, m_ir, man_ir = '0;
  logic         use_model = 1'b0;
  int           checks = 0, errors = 0;
  cpu_run_ctrl_if #(.WORD_W(32)) ld ();
  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .max_cycles(max_cycles),
    .ld(ld), .ram(ram), .core_reset(core_reset), .core_pc(core_pc), .core_ir(core_ir),
    .busy(busy), .done(done), .status(status), .cycles(cycles)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    if (core_reset) begin
      m_pc <= '0;
      m_ir <= '0;
    end else begin
      m_ir <= m_pc < 8'd8 ? ram[32*m_pc +: 32] : 32'h0;
      m_pc <= m_pc + 8'd1;
    end
  assign core_pc = use_model ? m_pc : man_pc;
  assign core_ir = use_model ? m_ir : man_ir;

  function automatic logic [31:0] w(input int i);
    return ram[i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] mx);
    start = 1'b1;
    max_cycles = mx;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld.ld_valid = 1'b1;
    ld.ld_data = d;
    ld.ld_last = last;
    tick();
    ld.ld_valid = 1'b0;
    ld.ld_last = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({core_reset, ld.ld_ready, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: cr/rdy/busy/done=%b required 1000", {core_reset, ld.ld_ready, busy, done});
    end
    checks++;
    if (status !== 2'd0 || cycles !== 16'd0 || ram !== '0) begin
      errors++;
      $display("FAIL reset_vals: status=%0d cycles=%0d ram_nz=%b required 0 0 0", status, cycles, |ram);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    int n;
    use_model = 1'b1;
    do_start(16'd100);
    checks++;
    if (ld.ld_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_load: ld_ready=%b busy=%b required 1 1", ld.ld_ready, busy);
    end
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    beat(HW, 1'b1);
    checks++;
    if (ld.ld_ready !== 1'b0 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL halt_run: ld_ready=%b core_reset=%b required 0 0", ld.ld_ready, core_reset);
    end
    wait_done(20, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL halt_latency: %0d cycles after last beat, required 4", n);
    end
    checks++;
    if (status !== 2'd0 || cycles !== 16'd3) begin
      errors++;
      $display("FAIL halt_status: status=%0d cycles=%0d required 0 3", status, cycles);
    end
    checks++;
    if (w(0) !== 32'h11 || w(1) !== 32'h22 || w(2) !== HW || ram[255:96] !== '0) begin
      errors++;
      $display("FAIL halt_ram: w0=%h w1=%h w2=%h hi_nz=%b required 11 22 ffffffff 0", w(0), w(1), w(2), |ram[255:96]);
    end
    checks++;
    if (core_reset !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_core_reset: core_reset=%b busy=%b required 1 0", core_reset, busy);
    end
  endtask

  task automatic test_full();
    int n;
    use_model = 1'b1;
    do_start(16'd0);
    for (int i = 0; i < 8; i++) beat(32'(i + 1), 1'b0);
    checks++;
    if (ld.ld_ready !== 1'b0 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL full_run: ld_ready=%b core_reset=%b required 0 0", ld.ld_ready, core_reset);
    end
    beat(32'hDEAD, 1'b0);
    checks++;
    if (w(0) !== 32'd1 || w(7) !== 32'd8) begin
      errors++;
      $display("FAIL full_ram: w0=%h w7=%h required 1 8", w(0), w(7));
    end
    wait_done(30, n);
    checks++;
    if (status !== 2'd2) begin
      errors++;
      $display("FAIL full_pc_range: status=%0d required 2", status);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic seen;
    use_model = 1'b0;
    man_pc = '0;
    man_ir = '0;
    do_start(16'd5);
    beat(32'h1, 1'b1);
    wait_done(20, n);
    checks++;
    if (status !== 2'd1 || cycles !== 16'd5 || n !== 6) begin
      errors++;
      $display("FAIL timeout: status=%0d cycles=%0d lat=%0d required 1 5 6", status, cycles, n);
    end
    do_start(16'd0);
    beat(32'h1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      seen |= done;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL no_limit: done=%b seen during 1000 cycles, required 0", seen);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 2'd3 || cycles !== 16'd1000) begin
      errors++;
      $display("FAIL no_limit_abort: done=%b status=%0d cycles=%0d required 1 3 1000", done, status, cycles);
    end
  endtask

  task automatic test_pc_range();
    use_model = 1'b0;
    man_pc = '0;
    man_ir = '0;
    do_start(16'd0);
    beat(32'h1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    man_pc = 8'd8;
    tick();
    man_pc = '0;
    checks++;
    if (done !== 1'b1 || status !== 2'd2 || cycles !== 16'd3) begin
      errors++;
      $display("FAIL pc_range: done=%b status=%0d cycles=%0d required 1 2 3", done, status, cycles);
    end
    do_start(16'd0);
    beat(32'h1, 1'b1);
    tick();
    man_pc = 8'd9;
    man_ir = HW;
    tick();
    man_pc = '0;
    man_ir = '0;
    checks++;
    if (done !== 1'b1 || status !== 2'd0 || cycles !== 16'd1) begin
      errors++;
      $display("FAIL halt_over_pc: done=%b status=%0d cycles=%0d required 1 0 1", done, status, cycles);
    end
  endtask

  task automatic test_abort_reset();
    use_model = 1'b0;
    do_start(16'd0);
    beat(32'h11, 1'b0);
    abort = 1'b1;
    beat(32'h22, 1'b0);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 2'd3 || ld.ld_ready !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL abort_load: done=%b status=%0d rdy=%b cr=%b required 1 3 0 1", done, status, ld.ld_ready, core_reset);
    end
    checks++;
    if (w(0) !== 32'h11 || w(1) !== 32'h0) begin
      errors++;
      $display("FAIL abort_ram: w0=%h w1=%h required 11 0", w(0), w(1));
    end
    do_start(16'd0);
    beat(32'h5, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (core_reset !== 1'b1 || cycles !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || ram !== '0) begin
      errors++;
      $display("FAIL reset_run: cr=%b cycles=%0d busy=%b done=%b ram_nz=%b required 1 0 0 0 0", core_reset, cycles, busy, done, |ram);
    end
    start = 1'b0;
    tick();
    checks++;
    if (ld.ld_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ld_ready=%b busy=%b required 0 0", ld.ld_ready, busy);
    end
  endtask

  task automatic test_restart();
    int n;
    use_model = 1'b1;
    do_start(16'd0);
    beat(32'h33, 1'b0);
    beat(HW, 1'b1);
    wait_done(20, n);
    do_start(16'd100);
    checks++;
    if (done !== 1'b0 || cycles !== 16'd0 || ram !== '0 || ld.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: done=%b cycles=%0d ram_nz=%b rdy=%b required 0 0 0 1", done, cycles, |ram, ld.ld_ready);
    end
    beat(32'h5, 1'b0);
    beat(HW, 1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ld.ld_ready !== 1'b0 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: busy=%b rdy=%b cr=%b required 1 0 0", busy, ld.ld_ready, core_reset);
    end
    wait_done(20, n);
    checks++;
    if (status !== 2'd0 || cycles !== 16'd2 || w(0) !== 32'h5 || w(1) !== HW) begin
      errors++;
      $display("FAIL restart_halt: status=%0d cycles=%0d w0=%h w1=%h required 0 2 5 ffffffff", status, cycles, w(0), w(1));
    end
  endtask

  initial begin
    ld.ld_valid = 1'b0;
    ld.ld_last = 1'b0;
    ld.ld_data = '0;
    test_reset();
    test_halt();
    test_full();
    test_timeout();
    test_pc_range();
    test_abort_reset();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller that sits between a program source and the `cpu` core. It streams a program image into the core's flat RAM input and holds the core in reset while loading. It then releases the core and watches its `pc`/`ir` until halt, out-of-range PC, timeout or abort, and reports status and cycle count. It replaces fixed-delay bench runs and is parametrised in RAM depth, word width, PC width and counter width.

## Interface
- `RAM_SIZE`, 8: number of program words in the image.
- `WORD_W`, 32: instruction/RAM word width.
- `PC_W`, 8: width of core PC.
- `CNT_W`, 16: cycle counter width.
- `HALT_WORD`, 32'hFFFF_FFFF: `ir` value that signals a halt. Truncated to `WORD_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin load+run.
- `abort` in 1: terminate current load/run.
- `max_cycles` in CNT_W: run limit, sampled on accepted `start`. 0 means no limit.
- `ld_valid` in 1: load beat valid.
- `ld_ready` out 1: load beat accepted when `ld_valid` and `ld_ready` are both high.
- `ld_data` in WORD_W: program word.
- `ld_last` in 1: final word of the image.
- `ram` out RAM_SIZE*WORD_W: flat image. Word i occupies bits `[(i+1)*WORD_W-1 -: WORD_W]`.
- `core_reset` out 1: drives the core's `reset`.
- `core_pc` in PC_W: core `pc`.
- `core_ir` in WORD_W: core `ir`.
- `busy` out 1: high in LOAD or RUN.
- `done` out 1: high in DONE.
- `status` out 2: 0 HALT, 1 TIMEOUT, 2 PC_RANGE, 3 ABORT.
- `cycles` out CNT_W: RUN cycles elapsed.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset values: state IDLE, `ram` all 0, `core_reset` 1, `ld_ready` 0, `busy` 0, `done` 0, `status` 0, `cycles` 0, word index 0.
- IDLE or DONE:
  - `start` moves to LOAD.
  - On the same edge: clear `ram` to 0, index 0, `cycles` 0, latch `max_cycles`, clear `done`.
- LOAD:
  - `ld_ready` is 1.
  - Each accepted beat writes `ld_data` to word[index] and increments index.
  - An accepted beat with `ld_last`, or an accepted beat at index RAM_SIZE-1, moves to RUN.
  - Unwritten words stay 0.
- RUN:
  - `core_reset` is 0.
  - Each cycle the checks are evaluated in this priority order:
    1. `cycles`≠0 and `core_ir`==HALT_WORD gives HALT.
    2. `cycles`≠0 and `core_pc`≥RAM_SIZE gives PC_RANGE.
    3. latched max≠0 and `cycles`==max gives TIMEOUT.
    4. Otherwise `cycles` increments, saturating at all-ones.
  - Any detected condition moves to DONE with the corresponding status.
- `abort` in LOAD or RUN moves to DONE with ABORT. `abort` outranks every RUN check and any load beat in the same cycle; that beat is not written.
- `start` in LOAD or RUN is ignored. `abort` in IDLE or DONE is ignored.
- `core_reset` is 1 in every state except RUN. It is reasserted on the edge that leaves RUN.
- DONE: `status`, `cycles` and `ram` are held until the next `start` or `reset`.
- `reset` mid-LOAD or mid-RUN returns everything to reset values on that edge.

## Timing
- All outputs are registered.
- `ld_ready` rises the cycle after `start`. It falls in the cycle after the final beat or an abort.
- `core_reset` falls the cycle after the final load beat. That cycle is the core's first clock out of reset, and its outputs are not checked.
- `done` rises the cycle after the terminating condition is sampled.
- `cycles` in DONE equals the number of RUN cycles completed before the terminating check. For TIMEOUT, `cycles` == `max_cycles`.
- Load throughput: one word per cycle.
- Minimum total latency from `start` to `done` with N words: 1 + N + 2 cycles (halt at the earliest check).

## Structure
- Shared package `cpu_pkg`:
  - state enum (IDLE/LOAD/RUN/DONE);
  - status codes (ST_HALT/ST_TIMEOUT/ST_PC_RANGE/ST_ABORT);
  - default HALT_WORD constant.
- One sub-module, `cpu_ram_image`: a flat RAM_SIZE×WORD_W register array with synchronous clear and indexed write, exposing the flat bus.
- The FSM, counter and checks live in `cpu_run_ctrl`.

## Test plan
- **Normal load and halt:** `start` with max_cycles=100, load 3 words (last word HALT_WORD, `ld_last` on beat 3), core model steps `ir` through the words one per cycle → `done`=1, `status`=0, `cycles`=3, `ram` words 3..7 = 0, `core_reset` high again.
- **Full image without `ld_last`:** stream 8 beats with `ld_last` held low → RUN entered after beat 8. Assert `ld_valid` for a 9th beat: `ld_ready` is 0 and the beat is not written.
- **Timeout:** max_cycles=5, core never halts, pc stays at 0 → `status`=1, `cycles`=5. With max_cycles=0 over 1000 cycles, `done` stays 0.
- **PC range:** core `pc` jumps to 8 on the 4th RUN cycle → `status`=2. With HALT_WORD and pc=9 presented together → `status`=0.
- **Abort and reset:**
  - `abort` together with `ld_valid` mid-LOAD → status 3, and that word is not written.
  - `reset` mid-RUN → `core_reset`=1, `cycles`=0, state IDLE the next cycle.
- **Restart:** `start` in DONE → `ram` cleared, `cycles`=0, `done`=0, second program runs to HALT. `start` during RUN has no effect.
